// File: rtl/debug_pkg.sv
// Shared debugger definitions: serializer FSM states and default frame geometry,
// common to the buffer assembler and the UART serializer.
package debug_pkg;

  localparam int DBG_NUM_BYTES = 148;
  localparam int DBG_BYTE_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_CHK  = 2'd2
  } ser_state_t;

endpackage

// File: rtl/serializador_envio.sv
// Frame serializer: snapshots buffer_envio on an accepted start and streams it
// LSB byte first over a valid/ready handshake toward the UART transmitter.
// Optional build macro CHECKSUM_EN appends an XOR checksum word after the data.
module serializador_envio
  import debug_pkg::*;
#(
  parameter int NUM_BYTES = DBG_NUM_BYTES,
  parameter int BYTE_W    = DBG_BYTE_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_BYTES*BYTE_W-1:0]    buffer_envio,
  input  logic                           start,
  output logic [BYTE_W-1:0]              tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(NUM_BYTES+1)-1:0] byte_idx
);

  localparam int W  = NUM_BYTES * BYTE_W;
  localparam int IW = $clog2(NUM_BYTES + 1);
  localparam int SW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_BYTES - 1);

  ser_state_t        state, state_nx;
  logic [W-1:0]      shadow;
  logic [IW-1:0]     idx_nx;
  logic              done_nx;
  logic [SW-1:0]     base;
  logic [BYTE_W-1:0] word;
  logic              xfer;
`ifdef CHECKSUM_EN
  logic [BYTE_W-1:0] csum;
`endif

  // Word select from the frozen snapshot and handshake-derived outputs
  always_comb begin
    base     = SW'(int'(byte_idx) * BYTE_W);
    word     = shadow[base +: BYTE_W];
    tx_valid = (state != ST_IDLE);
    busy     = (state != ST_IDLE);
    xfer     = tx_valid & tx_ready;
    tx_data  = '0;
    if (state == ST_SEND) tx_data = word;
`ifdef CHECKSUM_EN
    if (state == ST_CHK)  tx_data = csum;
`endif
  end

  // Next-state, next index and done pulse
  always_comb begin
    state_nx = state;
    idx_nx   = byte_idx;
    done_nx  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_SEND;
          idx_nx   = '0;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          if (byte_idx == LAST) begin
`ifdef CHECKSUM_EN
            state_nx = ST_CHK;
            idx_nx   = IW'(NUM_BYTES);
`else
            state_nx = ST_IDLE;
            idx_nx   = '0;
            done_nx  = 1'b1;
`endif
          end else begin
            idx_nx = byte_idx + 1'b1;
          end
        end
      end
`ifdef CHECKSUM_EN
      ST_CHK: begin
        if (xfer) begin
          state_nx = ST_IDLE;
          idx_nx   = '0;
          done_nx  = 1'b1;
        end
      end
`endif
      default: begin
        state_nx = ST_IDLE;
        idx_nx   = '0;
      end
    endcase
  end

  // State, index and done registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      byte_idx <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      byte_idx <= idx_nx;
      done     <= done_nx;
    end
  end

  // Snapshot of the frame, taken only when a start is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          shadow <= '0;
    else if (state == ST_IDLE && start)  shadow <= buffer_envio;
  end

`ifdef CHECKSUM_EN
  // Running XOR of transferred data words, cleared at frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          csum <= '0;
    else if (state == ST_IDLE && start)  csum <= '0;
    else if (state == ST_SEND && xfer)   csum <= csum ^ word;
  end
`endif

endmodule

// File: tb/tb_serializador_envio.sv
// Testbench for serializador_envio: a 4-byte instance for directed and random
// frames and a 148-byte instance for long random-backpressure frames, both
// scored against a queue model of the expected word stream.
module tb_serializador_envio;

  localparam int NA = 4;
  localparam int NB = 148;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-byte instance
  logic              a_rst_n, a_start, a_rdy, a_valid, a_busy, a_done;
  logic [NA*8-1:0]   a_buf;
  logic [7:0]        a_data;
  logic [2:0]        a_idx;

  // 148-byte instance
  logic              b_rst_n, b_start, b_rdy, b_valid, b_busy, b_done;
  logic [NB*8-1:0]   b_buf;
  logic [7:0]        b_data;
  logic [7:0]        b_idx;

  serializador_envio #(.NUM_BYTES(NA), .BYTE_W(8)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .buffer_envio(a_buf), .start(a_start),
    .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_rdy),
    .busy(a_busy), .done(a_done), .byte_idx(a_idx)
  );

  serializador_envio #(.NUM_BYTES(NB), .BYTE_W(8)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .buffer_envio(b_buf), .start(b_start),
    .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_rdy),
    .busy(b_busy), .done(b_done), .byte_idx(b_idx)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
  endtask

  // Reference model: each queue entry is idx*256 + data of a word still owed.
  int qa[$];
  int qb[$];
  bit da, db;

  always @(posedge clk or negedge a_rst_n) begin : model_a
    logic [7:0] w, cs;
    if (!a_rst_n) begin
      qa.delete();
      da = 1'b0;
    end else begin
      da = 1'b0;
      if (qa.size() > 0) begin
        if (a_rdy) begin
          void'(qa.pop_front());
          if (qa.size() == 0) da = 1'b1;
        end
      end else if (a_start) begin
        cs = 8'h00;
        for (int k = 0; k < NA; k++) begin
          w  = 8'(a_buf >> (8 * k));
          cs = cs ^ w;
          qa.push_back(k * 256 + int'(w));
        end
`ifdef CHECKSUM_EN
        qa.push_back(NA * 256 + int'(cs));
`endif
      end
    end
  end

  always @(posedge clk or negedge b_rst_n) begin : model_b
    logic [7:0] w, cs;
    if (!b_rst_n) begin
      qb.delete();
      db = 1'b0;
    end else begin
      db = 1'b0;
      if (qb.size() > 0) begin
        if (b_rdy) begin
          void'(qb.pop_front());
          if (qb.size() == 0) db = 1'b1;
        end
      end else if (b_start) begin
        cs = 8'h00;
        for (int k = 0; k < NB; k++) begin
          w  = 8'(b_buf >> (8 * k));
          cs = cs ^ w;
          qb.push_back(k * 256 + int'(w));
        end
`ifdef CHECKSUM_EN
        qb.push_back(NB * 256 + int'(cs));
`endif
      end
    end
  end

  // Compare both instances against the model on the falling edge
  always @(negedge clk) begin
    chk("a_valid", a_valid, qa.size() > 0);
    chk("a_busy",  a_busy,  qa.size() > 0);
    chk("a_done",  a_done,  da);
    if (qa.size() > 0) begin
      chk("a_data", a_data, qa[0] % 256);
      chk("a_idx",  a_idx,  qa[0] / 256);
    end
    chk("b_valid", b_valid, qb.size() > 0);
    chk("b_busy",  b_busy,  qb.size() > 0);
    chk("b_done",  b_done,  db);
    if (qb.size() > 0) begin
      chk("b_data", b_data, qb[0] % 256);
      chk("b_idx",  b_idx,  qb[0] / 256);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_a_reset(input string tag);
    chk({tag, "_data"},  a_data,  0);
    chk({tag, "_valid"}, a_valid, 0);
    chk({tag, "_busy"},  a_busy,  0);
    chk({tag, "_done"},  a_done,  0);
    chk({tag, "_idx"},   a_idx,   0);
  endtask

  task automatic seq_a();
    a_rst_n = 1'b0; a_start = 1'b0; a_rdy = 1'b0; a_buf = '0;
    step(2);
    check_a_reset("a_rst");
    a_rst_n = 1'b1;
    step(1);
    // plain frame, always ready
    a_buf = 32'h04030201; a_rdy = 1'b1; a_start = 1'b1;
    step(1); a_start = 1'b0;
    step(8);
    // backpressure while word 02 is presented
    a_start = 1'b1;
    step(1); a_start = 1'b0;
    step(1); a_rdy = 1'b0;
    step(3); a_rdy = 1'b1;
    step(8);
    // start re-pulsed and buffer overwritten mid-frame
    a_start = 1'b1;
    step(1); a_start = 1'b0;
    step(1); a_start = 1'b1; a_buf = 32'hFFFFFFFF;
    step(1); a_start = 1'b0;
    step(8);
    // reset while word 03 is presented, then a fresh frame
    a_buf = 32'h04030201;
    a_start = 1'b1;
    step(1); a_start = 1'b0;
    step(2);
    #2 a_rst_n = 1'b0;
    #1 check_a_reset("a_abort");
    step(1); a_rst_n = 1'b1;
    step(1); a_start = 1'b1;
    step(1); a_start = 1'b0;
    step(8);
    // random starts, backpressure and buffer changes
    for (int unsigned c = 0; c < 300; c++) begin
      a_start = ($urandom_range(0, 7) == 0);
      a_rdy   = ($urandom_range(0, 1) == 1);
      a_buf   = $urandom;
      step(1);
    end
    a_start = 1'b0; a_rdy = 1'b1;
    step(10);
  endtask

  task automatic seq_b();
    b_rst_n = 1'b0; b_start = 1'b0; b_rdy = 1'b0; b_buf = '0;
    step(2);
    b_rst_n = 1'b1;
    // start held high: each new frame begins in the done cycle of the previous one
    b_start = 1'b1;
    for (int unsigned c = 0; c < 700; c++) begin
      for (int unsigned k = 0; k < NB / 4; k++) b_buf[k*32 +: 32] = $urandom;
      b_rdy = ($urandom_range(0, 3) != 0);
      step(1);
    end
    b_start = 1'b0; b_rdy = 1'b1;
    step(200);
  endtask

  initial begin
    fork
      seq_a();
      seq_b();
    join
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
